// File: rtl/qtable_arb_pkg.sv
// Shared definitions for the Q-table access arbiter: requester ids, FSM states, defaults.
package qtable_arb_pkg;

    localparam int unsigned NUM_REQ        = 3;
    localparam int unsigned REQ_LEARN      = 0;
    localparam int unsigned REQ_PLAN       = 1;
    localparam int unsigned REQ_HOST       = 2;

    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StAccess   = 2'd1,
        StLockWait = 2'd2
    } arb_state_e;

    // Requester index to one-hot request/grant vector.
    function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Round-robin successor, (idx + 1) mod 3.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational 3-way round-robin picker: first requester at or after the pointer wins.
module rr_priority_picker
    import qtable_arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] win_o,
    output logic [1:0] win_idx_o
);

    // Scan requesters in rotated order and keep the first one found.
    always_comb begin
        logic [1:0] order [3];
        logic       found;
        case (ptr_i)
            2'd1: begin
                order[0] = 2'd1;
                order[1] = 2'd2;
                order[2] = 2'd0;
            end
            2'd2: begin
                order[0] = 2'd2;
                order[1] = 2'd0;
                order[2] = 2'd1;
            end
            default: begin
                order[0] = 2'd0;
                order[1] = 2'd1;
                order[2] = 2'd2;
            end
        endcase
        found     = 1'b0;
        win_o     = 3'b000;
        win_idx_o = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!found && ((req_i & idx_onehot(order[k])) != 3'b000)) begin
                found     = 1'b1;
                win_o     = idx_onehot(order[k]);
                win_idx_o = order[k];
            end
        end
    end

endmodule

// File: rtl/qtable_access_arbiter.sv
// Single-port Q-table RAM arbiter for learner, planner and host, with locked RMW sequences.
module qtable_access_arbiter
    import qtable_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned LOCK_TIMEOUT = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    arb_enable_i,
    input  logic [2:0]              req_i,
    input  logic [2:0]              we_i,
    input  logic [2:0]              lock_i,
    input  logic [3*ADDR_WIDTH-1:0] addr_i,
    input  logic [3*DATA_WIDTH-1:0] wdata_i,
    output logic [2:0]              gnt_o,
    output logic [2:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    locked_o,
    output logic [1:0]              owner_o,
    output logic                    timeout_err_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned CntW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam bit             TimeoutEn  = (LOCK_TIMEOUT != 0);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(LOCK_TIMEOUT);

    arb_state_e state_q, state_d;

    logic [1:0]            rr_q, rr_d;
    logic [1:0]            owner_q, owner_d;
    logic                  we_q, we_d;
    logic                  lock_q, lock_d;
    logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;

    logic [2:0]            gnt_q, gnt_d;
    logic [2:0]            rvalid_q, rvalid_d;
    logic                  locked_q, locked_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [2:0]            pick_req, pick_win;
    logic [1:0]            pick_idx;
    logic                  owner_req, timeout_hit, timeout_fire;
    logic                  grant_en;
    logic [1:0]            grant_idx;
    logic                  sel_we, sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Only IDLE arbitrates; a held lock bypasses the picker entirely.
    assign pick_req = (state_q == StIdle && arb_enable_i) ? req_i : 3'b000;

    rr_priority_picker u_picker (
        .req_i     (pick_req),
        .ptr_i     (rr_q),
        .win_o     (pick_win),
        .win_idx_o (pick_idx)
    );

    assign owner_req   = |(req_i & idx_onehot(owner_q));
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = TimeoutEn && (cnt_inc == TimeoutVal);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant decision and lock bookkeeping.
    always_comb begin
        state_d      = state_q;
        grant_en     = 1'b0;
        grant_idx    = owner_q;
        timeout_fire = 1'b0;
        case (state_q)
            StIdle: begin
                if (pick_win != 3'b000) begin
                    state_d   = StAccess;
                    grant_en  = 1'b1;
                    grant_idx = pick_idx;
                end
            end
            StAccess: begin
                state_d = lock_q ? StLockWait : StIdle;
            end
            StLockWait: begin
                if (owner_req) begin
                    state_d   = StAccess;
                    grant_en  = 1'b1;
                    grant_idx = owner_q;
                end else if (timeout_hit) begin
                    state_d      = StIdle;
                    timeout_fire = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        we_d   = grant_en ? sel_we : we_q;
        lock_d = grant_en ? sel_lock : lock_q;
        // Counter runs only while the owner is silent; any other state clears it.
        cnt_d  = (state_q == StLockWait && !owner_req) ? cnt_inc : '0;
        rr_d   = rr_q;
        if ((state_q == StAccess && !lock_q) || timeout_fire) begin
            rr_d = next_idx(owner_q);
        end
    end

    // Select the winning requester's access fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant_idx == 2'(i)) begin
                sel_we    = we_i[i];
                sel_lock  = lock_i[i];
                sel_addr  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Registered outputs, computed from the upcoming state so gnt lines up with ACCESS.
    always_comb begin
        gnt_d         = grant_en ? idx_onehot(grant_idx) : 3'b000;
        mem_en_d      = grant_en;
        mem_we_d      = grant_en & sel_we;
        mem_addr_d    = grant_en ? sel_addr : mem_addr_q;
        mem_wdata_d   = grant_en ? sel_wdata : mem_wdata_q;
        rvalid_d      = (state_q == StAccess && !we_q) ? idx_onehot(owner_q) : 3'b000;
        owner_d       = grant_en ? grant_idx : owner_q;
        timeout_err_d = timeout_fire;
        case (state_d)
            StLockWait: locked_d = 1'b1;
            StIdle:     locked_d = 1'b0;
            default:    locked_d = locked_q;
        endcase
    end

    // Datapath and output registers; reset also drops any lock and pending rvalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q          <= 2'd0;
            owner_q       <= 2'd0;
            we_q          <= 1'b0;
            lock_q        <= 1'b0;
            cnt_q         <= '0;
            gnt_q         <= 3'b000;
            rvalid_q      <= 3'b000;
            locked_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            rr_q          <= rr_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            lock_q        <= lock_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            rvalid_q      <= rvalid_d;
            locked_q      <= locked_d;
            timeout_err_q <= timeout_err_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign rvalid_o      = rvalid_q;
    assign rdata_o       = mem_rdata_i;
    assign locked_o      = locked_q;
    assign owner_o       = owner_q;
    assign timeout_err_o = timeout_err_q;
    assign mem_en_o      = mem_en_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule
